// File: rtl/bm_pkg.sv
// rtl/bm_pkg.sv - shared types and defaults for the disparity-fraction divider path
package bm_pkg;

   localparam int CH_L   = 0;
   localparam int CH_R   = 1;
   localparam int BM_DW  = 18;
   localparam int BM_QW  = 8;
   localparam int BM_LAT = 17;

   typedef struct packed {
      logic valid;
      logic ch;
      logic zero;
   } tag_t;

endpackage

// File: rtl/bm_frac_fifo.sv
// rtl/bm_frac_fifo.sv - synchronous show-ahead result FIFO, one per channel
module bm_frac_fifo
   import bm_pkg::*;
#(
   parameter int W     = BM_QW + 1,
   parameter int DEPTH = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_pop;

   assign o_valid  = (r_count != '0);
   assign w_do_pop = i_pop && o_valid;
   // head reads as zero while empty so the outputs are clean out of reset
   assign o_data   = o_valid ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push)   r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
         if (w_do_pop) r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
         if (i_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (!i_push && w_do_pop) r_count <= r_count - 1'b1;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_push && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/bm_frac_arb.sv
// rtl/bm_frac_arb.sv - two-channel round-robin front end for the shared fraction divider
module bm_frac_arb
   import bm_pkg::*;
#(
   parameter int DW    = BM_DW,
   parameter int QW    = BM_QW,
   parameter int LAT   = BM_LAT,
   parameter int DEPTH = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [2*DW-1:0] req_dividend,
   input  logic [2*DW-1:0] req_divisor,
   output logic            div_vin,
   output logic [DW-1:0]   div_dividend,
   output logic [DW-1:0]   div_divisor,
   input  logic            div_vout,
   input  logic [QW-1:0]   div_quotient,
   output logic [1:0]      res_valid,
   input  logic [1:0]      res_ready,
   output logic [2*QW-1:0] res_quotient,
   output logic [1:0]      res_zero,
   output logic            busy,
   output logic            err_tag
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] r_credit [2];
   logic          r_last_grant;
   logic          r_div_vin;
   logic [DW-1:0] r_div_dividend;
   logic [DW-1:0] r_div_divisor;
   logic          r_err_tag;
   tag_t          r_tag [LAT+1];

   logic [1:0]    w_elig;
   logic [1:0]    w_grant;
   logic [1:0]    w_pop;
   logic [1:0]    w_push;
   logic          w_acc;
   logic          w_ch;
   logic [DW-1:0] w_dividend;
   logic [DW-1:0] w_divisor;
   tag_t          w_head;
   tag_t          w_new_tag;
   logic          w_fvalid [2];
   logic [QW:0]   w_fdata  [2];

   // credit covers in-flight plus queued results, so a granted op always has a FIFO slot
   assign w_elig[CH_L] = rst_n && en && req_valid[CH_L] && (r_credit[CH_L] < CW'(DEPTH));
   assign w_elig[CH_R] = rst_n && en && req_valid[CH_R] && (r_credit[CH_R] < CW'(DEPTH));

   always_comb begin
      w_grant = w_elig;
      if (&w_elig) w_grant = r_last_grant ? 2'b01 : 2'b10;
   end

   assign req_ready  = w_grant;
   assign w_acc      = |w_grant;
   assign w_ch       = w_grant[CH_R];
   assign w_dividend = w_ch ? req_dividend[DW +: DW] : req_dividend[0 +: DW];
   assign w_divisor  = w_ch ? req_divisor[DW +: DW]  : req_divisor[0 +: DW];
   assign w_new_tag  = '{valid: w_acc, ch: w_ch, zero: (w_divisor == '0)};

   // stage 0 shadows div_vin, so stage LAT lines up with div_vout
   assign w_head = r_tag[LAT];
   assign w_push = w_head.valid ? (w_head.ch ? 2'b10 : 2'b01) : 2'b00;
   assign w_pop  = res_valid & res_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant   <= 1'b1;
         r_div_vin      <= 1'b0;
         r_div_dividend <= '0;
         r_div_divisor  <= '0;
         r_err_tag      <= 1'b0;
         for (int i = 0; i <= LAT; i++) r_tag[i] <= '0;
      end else begin
         r_div_vin <= w_acc;
         if (w_acc) begin
            r_last_grant   <= w_ch;
            r_div_dividend <= w_dividend;
            r_div_divisor  <= w_divisor;
         end
         r_tag[0] <= w_new_tag;
         for (int i = 1; i <= LAT; i++) r_tag[i] <= r_tag[i-1];
         if (w_head.valid != div_vout) r_err_tag <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) r_credit[c] <= '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (w_grant[c] && !w_pop[c])      r_credit[c] <= r_credit[c] + 1'b1;
            else if (!w_grant[c] && w_pop[c]) r_credit[c] <= r_credit[c] - 1'b1;
         end
      end
   end

   generate
      for (genvar c = 0; c < 2; c++) begin : g_ch
         bm_frac_fifo #(
            .W     (QW + 1),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[c]),
            .i_data  ({w_head.zero, div_quotient}),
            .i_pop   (res_ready[c]),
            .o_valid (w_fvalid[c]),
            .o_data  (w_fdata[c])
         );
      end
   endgenerate

   assign res_valid    = {w_fvalid[1], w_fvalid[0]};
   assign res_quotient = {w_fdata[1][QW-1:0], w_fdata[0][QW-1:0]};
   assign res_zero     = {w_fdata[1][QW], w_fdata[0][QW]};
   assign busy         = (r_credit[CH_L] != '0) || (r_credit[CH_R] != '0);
   assign div_vin      = r_div_vin;
   assign div_dividend = r_div_dividend;
   assign div_divisor  = r_div_divisor;
   assign err_tag      = r_err_tag;

endmodule

// File: tb/tb_bm_frac_arb.sv
// tb/tb_bm_frac_arb.sv - randomized scoreboard bench for bm_frac_arb
module tb_bm_frac_arb;
   import bm_pkg::*;

   localparam int DW    = BM_DW;
   localparam int QW    = BM_QW;
   localparam int LAT   = BM_LAT;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            en = 1'b0;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_ready;
   logic [2*DW-1:0] req_dividend = '0;
   logic [2*DW-1:0] req_divisor = '0;
   logic            div_vin;
   logic [DW-1:0]   div_dividend;
   logic [DW-1:0]   div_divisor;
   logic            div_vout;
   logic [QW-1:0]   div_quotient;
   logic [1:0]      res_valid;
   logic [1:0]      res_ready = '0;
   logic [2*QW-1:0] res_quotient;
   logic [1:0]      res_zero;
   logic            busy;
   logic            err_tag;

   always #5 clk = ~clk;

   bm_frac_arb #(.DW(DW), .QW(QW), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_dividend (req_dividend),
      .req_divisor  (req_divisor),
      .div_vin      (div_vin),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_vout     (div_vout),
      .div_quotient (div_quotient),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_quotient (res_quotient),
      .res_zero     (res_zero),
      .busy         (busy),
      .err_tag      (err_tag)
   );

   function automatic logic [QW-1:0] fdiv(input logic [DW-1:0] a, input logic [DW-1:0] b);
      longint unsigned n;
      if (b == '0) return a[QW-1:0] ^ QW'(8'h5A);
      n = 64'(a) << QW;
      n = n / 64'(b);
      return n[QW-1:0];
   endfunction

   // divider stand-in: not reset with the DUT, so late results can follow a reset
   bit   [LAT-1:0] p_v;
   logic [QW-1:0]  p_q [LAT];
   logic           inj = 1'b0;
   int             cyc = 0;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      p_v    <= {p_v[LAT-2:0], div_vin};
      p_q[0] <= fdiv(div_dividend, div_divisor);
      for (int i = 1; i < LAT; i++) p_q[i] <= p_q[i-1];
   end
   assign div_vout     = p_v[LAT-1] | inj;
   assign div_quotient = p_q[LAT-1];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   typedef struct { logic [QW:0] d; int vis; } ent_t;
   ent_t          eq [2][$];
   bit            vout_at [int];
   bit            tag_at  [int];
   logic          m_last = 1'b1;
   logic          m_err  = 1'b0;
   logic          m_vin  = 1'b0;
   logic [DW-1:0] m_dd = '0;
   logic [DW-1:0] m_ds = '0;

   task automatic cycle(input logic [1:0] v, input logic [1:0] rr, input logic e,
                        input logic rst_i, input logic inj_i,
                        input logic [2*DW-1:0] dd, input logic [2*DW-1:0] ds);
      logic [1:0] ev, elig, gnt;
      int         ch;
      ent_t       ent;
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
         ev[c] = (eq[c].size() > 0) && (eq[c][0].vis <= cyc);
         chk($sformatf("res_valid[%0d]", c), 64'(res_valid[c]), 64'(ev[c]));
         if (ev[c]) begin
            chk($sformatf("res_quotient[%0d]", c), 64'(res_quotient[c*QW +: QW]), 64'(eq[c][0].d[QW-1:0]));
            chk($sformatf("res_zero[%0d]", c), 64'(res_zero[c]), 64'(eq[c][0].d[QW]));
         end
      end
      chk("busy", 64'(busy), 64'((eq[0].size() + eq[1].size()) != 0));
      chk("err_tag", 64'(err_tag), 64'(m_err));
      chk("div_vin", 64'(div_vin), 64'(m_vin));
      if (m_vin) begin
         chk("div_dividend", 64'(div_dividend), 64'(m_dd));
         chk("div_divisor", 64'(div_divisor), 64'(m_ds));
      end

      rst_n = rst_i; en = e; req_valid = v; req_dividend = dd; req_divisor = ds;
      res_ready = rr; inj = inj_i;
      #1;
      for (int c = 0; c < 2; c++)
         elig[c] = rst_i && e && v[c] && (eq[c].size() < DEPTH);
      gnt = (&elig) ? (m_last ? 2'b01 : 2'b10) : elig;
      chk("req_ready", 64'(req_ready), 64'(gnt));

      if (!rst_i) begin
         eq[0].delete(); eq[1].delete(); tag_at.delete();
         m_last = 1'b1; m_err = 1'b0; m_vin = 1'b0; m_dd = '0; m_ds = '0;
         return;
      end
      if (inj_i) vout_at[cyc+1] = 1'b1;
      if (vout_at.exists(cyc+1) != tag_at.exists(cyc+1)) m_err = 1'b1;
      for (int c = 0; c < 2; c++)
         if (ev[c] && rr[c]) void'(eq[c].pop_front());
      m_vin = |gnt;
      if (|gnt) begin
         ch    = gnt[1] ? 1 : 0;
         m_dd  = dd[ch*DW +: DW];
         m_ds  = ds[ch*DW +: DW];
         ent.d   = {(m_ds == '0), fdiv(m_dd, m_ds)};
         ent.vis = cyc + 2 + LAT;
         eq[ch].push_back(ent);
         tag_at[cyc+2+LAT]  = 1'b1;
         vout_at[cyc+2+LAT] = 1'b1;
         m_last = gnt[1];
      end
   endtask

   function automatic logic [2*DW-1:0] rnd_ops(input bit allow_zero);
      logic [2*DW-1:0] r;
      for (int c = 0; c < 2; c++)
         r[c*DW +: DW] = (allow_zero && $urandom_range(0, 5) == 0) ? '0
                         : DW'($urandom_range(1, (1 << DW) - 1));
      return r;
   endfunction

   task automatic rcyc(input logic [1:0] v, input logic [1:0] rr, input logic e);
      cycle(v, rr, e, 1'b1, 1'b0, rnd_ops(1'b0), rnd_ops(1'b1));
   endtask

   initial begin
      repeat (3) cycle(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, '0, '0);
      chk("rst_res_quotient", 64'(res_quotient), 64'(0));
      chk("rst_res_zero", 64'(res_zero), 64'(0));
      chk("rst_div_dividend", 64'(div_dividend), 64'(0));
      chk("rst_div_divisor", 64'(div_divisor), 64'(0));

      // single left request, result held until visible then popped
      cycle(2'b01, 2'b00, 1'b1, 1'b1, 1'b0, {DW'(0), DW'(10)}, {DW'(0), DW'(40)});
      repeat (LAT + 4) rcyc(2'b00, 2'b00, 1'b1);
      repeat (4) rcyc(2'b00, 2'b01, 1'b1);

      // both channels saturated for 8 cycles
      repeat (8) rcyc(2'b11, 2'b11, 1'b1);
      repeat (LAT + 10) rcyc(2'b00, 2'b11, 1'b1);

      // right channel back-pressured, then released
      repeat (45) rcyc(2'b11, 2'b01, 1'b1);
      repeat (30) rcyc(2'b11, 2'b11, 1'b1);
      repeat (LAT + 12) rcyc(2'b00, 2'b11, 1'b1);

      // zero divisor on the right channel
      cycle(2'b10, 2'b11, 1'b1, 1'b1, 1'b0, rnd_ops(1'b0), {DW'(0), DW'(7)});
      repeat (LAT + 6) rcyc(2'b00, 2'b11, 1'b1);

      repeat (500) rcyc(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 7) != 0));
      repeat (LAT + 14) rcyc(2'b00, 2'b11, 1'b1);

      // spurious divider output with no tag behind it
      cycle(2'b00, 2'b11, 1'b1, 1'b1, 1'b1, '0, '0);
      repeat (8) rcyc(2'b00, 2'b11, 1'b1);
      repeat (6) rcyc(2'b11, 2'b11, 1'b1);
      repeat (LAT + 8) rcyc(2'b00, 2'b11, 1'b1);

      // reset with ops in flight; late divider results must be dropped
      repeat (2) cycle(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, '0, '0);
      repeat (5) rcyc(2'b11, 2'b00, 1'b1);
      rcyc(2'b00, 2'b00, 1'b1);
      repeat (2) cycle(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, rnd_ops(1'b0), rnd_ops(1'b0));
      repeat (LAT + 6) rcyc(2'b00, 2'b11, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bm_frac_arb.md
# bm_frac_arb

Round-robin scheduler that shares one pipelined fixed-latency divider (the sub-pixel fraction divider, LAT-cycle `diven`) between two disparity-fraction requesters: left-reference and right-reference matching. Accepts dividend/divisor pairs over valid/ready and issues at most one per cycle. Tracks each in-flight operation with a tag pipeline and returns quotients in order to per-channel result FIFOs. Per-channel credit counters keep a FIFO from ever overflowing, since the divider itself has no backpressure.

## Interface
- DW, 18, dividend/divisor width
- QW, 8, quotient width
- LAT, 17, divider latency (div_vin to div_vout, cycles)
- DEPTH, 32, per-channel result FIFO depth (≥1); DEPTH > LAT+2 sustains full rate
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  grant enable; low stops new grants, in-flight ops drain normally
- req_valid  in  2  per-channel request valid (bit0 = L, bit1 = R)
- req_ready  out  2  per-channel accept (combinational, one-hot or zero)
- req_dividend  in  2×DW  packed, channel c at [c*DW +: DW]
- req_divisor  in  2×DW  packed, same layout
- div_vin  out  1  divider input valid (registered)
- div_dividend, div_divisor  out  DW each  divider operands (registered)
- div_vout  in  1  divider output valid
- div_quotient  in  QW  divider result
- res_valid  out  2  per-channel result available
- res_ready  in  2  per-channel result pop
- res_quotient  out  2×QW  packed per-channel quotient
- res_zero  out  2  divisor was zero for this result
- busy  out  1  any credit nonzero
- err_tag  out  1  sticky: div_vout disagreed with tag pipeline

## Operation
- credit[c]: width clog2(DEPTH+1); counts in-flight ops plus FIFO occupancy. +1 on accept, −1 on pop (res_valid & res_ready). Both in the same cycle: unchanged.
- eligible[c] = en & req_valid[c] & (credit[c] < DEPTH). Strict: a pop in the same cycle does not make a full channel eligible.
- Arbitration: one grant per cycle. If only one channel is eligible, grant it. If both are eligible, grant the channel not granted last. last_grant updates only on a grant; reset value 1, so L wins the first tie.
- req_ready = grant (one-hot). Accept = req_valid & req_ready.
- On accept: register the operands onto div_dividend/div_divisor, set div_vin = 1 for one cycle, and push tag {valid = 1, ch, zero = (divisor == 0)} into a LAT-stage tag shift register. Idle cycles push valid = 0. Operands hold their last value when div_vin = 0.
- Tag head (stage LAT) aligns with div_vout:
  - head valid, div_vout = 1: write div_quotient and zero into FIFO[ch].
  - head valid, div_vout = 0: still write (quotient as on bus) and set err_tag.
  - head invalid, div_vout = 1: drop the value and set err_tag.
  - Credits stay consistent in all cases.
- FIFO: show-ahead. res_valid = not empty. res_quotient/res_zero show the head entry. The FIFO cannot overflow by construction. A push to a full FIFO is a design error (assertion).
- busy = |credit.
- Reset mid-operation: all credits, FIFOs, tags, last_grant and err_tag clear. In-flight divider results arriving later find invalid tags, are dropped, and set err_tag. Integration must reset the divider alongside this block.

## Timing
- Reset values: req_ready 0, div_vin 0, div_dividend/div_divisor 0, res_valid 0, res_quotient 0, res_zero 0, busy 0, err_tag 0.
- Accept at edge t → div_vin high in cycle t+1 → div_vout in cycle t+1+LAT → FIFO write at that edge → res_valid high from cycle t+2+LAT (empty FIFO).
- Throughput: 1 op/cycle total. Two saturated channels alternate L, R, L, R…
- busy falls the cycle after the last pop.
- Back-to-back pops are allowed. Pop and push on the same FIFO in the same cycle are both honored.

## Structure
- Package bm_pkg: tag struct {valid, ch, zero}, channel index constants CH_L = 0, CH_R = 1, default LAT/DW/QW constants shared with bm_calc_frac.
- Sub-module bm_frac_fifo (sync show-ahead FIFO, width QW+1, parameter DEPTH), instantiated once per channel.
- Top level holds the arbiter, credit counters, operand register and tag pipeline. The divider stays outside and is wired by the integrator.

## Test plan
- Single L request (dividend 10, divisor 40), divider model returns 0x40 → res_valid[0] at t+2+LAT, quotient 0x40, res_zero 0, busy falls after pop.
- Both channels held valid for 8 cycles, res_ready = 1 → grants L, R, L, R… (L first after reset), 4 results per channel, in order.
- DEPTH = 4, res_ready[1] = 0, R continuously valid → exactly 4 accepts on R, then req_ready[1] stays 0 while L continues at full rate. Releasing res_ready[1] resumes R.
- Divisor 0 on R → res_zero[1] = 1 with the quotient passed through from the bus.
- Inject a spurious div_vout with no tag → value dropped, err_tag = 1 and remains until rst_n.
- Assert rst_n low with 5 ops in flight → all outputs return to reset values. Late div_vout pulses produce no res_valid and set err_tag.
